// File: rtl/motor602_uart_cmd_rx.sv
// UART RX + command decoder: samples uRxI at mid-bit and decodes ASCII bytes into motor control pulses/levels.
// Latency: outputs rise 1 clock after the stop-bit mid-sample (~9.5*CLK_DIV + 3 clocks after the start edge).
// Backpressure: none; the serial line cannot be stalled, so every outcome is a 1-cycle pulse. Option: MOTOR602_RX_PARITY_EN (8E1).
module motor602_uart_cmd_rx #(
    parameter int CLK_DIV = 434,
    parameter int CNT_W   = 16
) (
    input  logic       clkI,
    input  logic       rstI,
    input  logic       uRxI,
    output logic [7:0] rxByteO,
    output logic       rxValidO,
    output logic       frameErrO,
    output logic       m3startO,
    output logic       m3forceStopO,
    output logic       m3freqINCo,
    output logic       m3freqDECo,
    output logic       m3powerINCo,
    output logic       m3powerDECo,
    output logic       m3invRotateO,
    output logic       unknownCmdO
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
`ifdef MOTOR602_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_ok;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             start_q, start_d;
    logic             fstop_q, fstop_d;
    logic             finc_q, finc_d;
    logic             fdec_q, fdec_d;
    logic             pinc_q, pinc_d;
    logic             pdec_q, pdec_d;
    logic             inv_q, inv_d;
    logic             unk_q, unk_d;

`ifdef MOTOR602_RX_PARITY_EN
    logic par_q, par_d;

    // even parity over data plus the received parity bit must be 0
    assign frame_ok = ~(^{shift_q, par_q});

    // parity bit capture register
    always_ff @(posedge clkI) begin
        if (rstI) par_q <= 1'b0;
        else      par_q <= par_d;
    end
`else
    assign frame_ok = 1'b1;
`endif

    // two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clkI) begin
        if (rstI) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uRxI;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM state, baud counter, shift register and registered outputs
    always_ff @(posedge clkI) begin
        if (rstI) begin
            state_q <= WAIT_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            start_q <= 1'b0;
            fstop_q <= 1'b0;
            finc_q  <= 1'b0;
            fdec_q  <= 1'b0;
            pinc_q  <= 1'b0;
            pdec_q  <= 1'b0;
            inv_q   <= 1'b0;
            unk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            start_q <= start_d;
            fstop_q <= fstop_d;
            finc_q  <= finc_d;
            fdec_q  <= fdec_d;
            pinc_q  <= pinc_d;
            pdec_q  <= pdec_d;
            inv_q   <= inv_d;
            unk_q   <= unk_d;
        end
    end

    // next-state, bit sampling and command decode at the stop-bit sample
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        start_d = 1'b0;
        fstop_d = 1'b0;
        finc_d  = 1'b0;
        fdec_d  = 1'b0;
        pinc_d  = 1'b0;
        pdec_d  = 1'b0;
        inv_d   = inv_q;
        unk_d   = 1'b0;
`ifdef MOTOR602_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            WAIT_IDLE: begin
                // after a break or reset, wait for the line to return high
                if (rx_s_q) state_d = IDLE;
            end
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef MOTOR602_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
`ifdef MOTOR602_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
`endif
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s_q && frame_ok) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                        case (shift_q)
                            8'h53:   start_d = 1'b1;
                            8'h58:   fstop_d = 1'b1;
                            8'h2B:   finc_d  = 1'b1;
                            8'h2D:   fdec_d  = 1'b1;
                            8'h55:   pinc_d  = 1'b1;
                            8'h44:   pdec_d  = 1'b1;
                            8'h52:   inv_d   = 1'b1;
                            8'h46:   inv_d   = 1'b0;
                            default: unk_d   = 1'b1;
                        endcase
                    end else begin
                        // bad stop (or parity): one error pulse, then wait for idle line
                        state_d = WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign rxByteO      = byte_q;
    assign rxValidO     = valid_q;
    assign frameErrO    = ferr_q;
    assign m3startO     = start_q;
    assign m3forceStopO = fstop_q;
    assign m3freqINCo   = finc_q;
    assign m3freqDECo   = fdec_q;
    assign m3powerINCo  = pinc_q;
    assign m3powerDECo  = pdec_q;
    assign m3invRotateO = inv_q;
    assign unknownCmdO  = unk_q;

endmodule

// File: tb/tb_motor602_uart_cmd_rx.sv
// Bench for motor602_uart_cmd_rx: drives serial frames and checks decoded outputs against a byte-level model.
// Latency: frames are bit-timed at CLK_DIV clocks per bit; outputs sampled on the falling clock edge.
// Backpressure: none; the sender never waits on the DUT, every wait is cycle-bounded.
module tb_motor602_uart_cmd_rx;

    localparam int CLK_DIV = 16;
`ifdef MOTOR602_RX_PARITY_EN
    localparam int LAT_MIN = 155 + CLK_DIV;
`else
    localparam int LAT_MIN = 155;
`endif
    localparam int LAT_MAX = LAT_MIN + 2;

    logic       clkI = 1'b0;
    logic       rstI = 1'b1;
    logic       uRxI = 1'b1;
    logic [7:0] rxByteO;
    logic       rxValidO, frameErrO, m3startO, m3forceStopO, m3freqINCo, m3freqDECo;
    logic       m3powerINCo, m3powerDECo, m3invRotateO, unknownCmdO;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;

    // event log written only by the monitor
    logic [7:0] ev_byte[$];
    logic [6:0] ev_pulse[$];
    logic       ev_inv[$];
    int         ev_cyc[$];
    logic [7:0] ferr_byte[$];
    int         stray_cnt = 0;

    motor602_uart_cmd_rx #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
        .clkI(clkI), .rstI(rstI), .uRxI(uRxI),
        .rxByteO(rxByteO), .rxValidO(rxValidO), .frameErrO(frameErrO),
        .m3startO(m3startO), .m3forceStopO(m3forceStopO),
        .m3freqINCo(m3freqINCo), .m3freqDECo(m3freqDECo),
        .m3powerINCo(m3powerINCo), .m3powerDECo(m3powerDECo),
        .m3invRotateO(m3invRotateO), .unknownCmdO(unknownCmdO)
    );

    always #5 clkI = ~clkI;
    always @(posedge clkI) cyc++;

    // monitor: log every valid byte with its pulses, every frame error, and stray pulses
    always @(negedge clkI) begin
        logic [6:0] pv;
        pv = {m3startO, m3forceStopO, m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo, unknownCmdO};
        if (rxValidO) begin
            ev_byte.push_back(rxByteO);
            ev_pulse.push_back(pv);
            ev_inv.push_back(m3invRotateO);
            ev_cyc.push_back(cyc);
        end else if (pv != 7'd0) begin
            stray_cnt++;
        end
        if (frameErrO) ferr_byte.push_back(rxByteO);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    // reference: which command pulse a received byte must produce
    function automatic logic [6:0] model_pulses(input logic [7:0] b);
        case (b)
            "S":       return 7'b1000000;
            "X":       return 7'b0100000;
            "+":       return 7'b0010000;
            "-":       return 7'b0001000;
            "U":       return 7'b0000100;
            "D":       return 7'b0000010;
            "R", "F":  return 7'b0000000;
            default:   return 7'b0000001;
        endcase
    endfunction

    task automatic bit_time(input logic v);
        uRxI = v;
        repeat (CLK_DIV) @(negedge clkI);
    endtask

    task automatic idle(input int n);
        uRxI = 1'b1;
        repeat (n) @(negedge clkI);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input logic par_flip);
        start_cyc = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef MOTOR602_RX_PARITY_EN
        bit_time((^b) ^ par_flip);
`else
        if (par_flip) begin end
`endif
        bit_time(stop_v);
        uRxI = 1'b1;
    endtask

    task automatic test_reset();
        rstI = 1'b1;
        repeat (3) @(negedge clkI);
        checks++;
        if ({rxByteO, rxValidO, frameErrO, m3invRotateO} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: byte=%h vld=%b ferr=%b inv=%b, required 00/0/0/0",
                     rxByteO, rxValidO, frameErrO, m3invRotateO);
        end
        checks++;
        if ({m3startO, m3forceStopO, m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo, unknownCmdO} !== 7'd0) begin
            errors++;
            $display("FAIL reset_pulses: nonzero pulse outputs during reset");
        end
        rstI = 1'b0;
        idle(3 * CLK_DIV);
    endtask

    task automatic test_single();
        int n0 = ev_byte.size();
        send(8'h53, 1'b1, 1'b0);
        idle(2 * CLK_DIV);
        checks++;
        if (ev_byte.size() - n0 != 1) begin
            errors++;
            $display("FAIL single_count: got %0d valid pulses, required 1", ev_byte.size() - n0);
        end else begin
            checks++;
            if (ev_byte[n0] !== 8'h53 || ev_pulse[n0] !== 7'b1000000) begin
                errors++;
                $display("FAIL single_S: byte=%h pulses=%b, required 53/1000000", ev_byte[n0], ev_pulse[n0]);
            end
            checks++;
            if (ev_cyc[n0] - start_cyc < LAT_MIN || ev_cyc[n0] - start_cyc > LAT_MAX) begin
                errors++;
                $display("FAIL single_latency: got %0d clocks, required %0d..%0d",
                         ev_cyc[n0] - start_cyc, LAT_MIN, LAT_MAX);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0 = ev_byte.size();
        int f0 = ferr_byte.size();
        send("R", 1'b1, 1'b0);
        send("+", 1'b1, 1'b0);
        send("F", 1'b1, 1'b0);
        idle(2 * CLK_DIV);
        checks++;
        if (ev_byte.size() - n0 != 3 || ferr_byte.size() != f0) begin
            errors++;
            $display("FAIL b2b_count: valid=%0d ferr=%0d, required 3/0", ev_byte.size() - n0, ferr_byte.size() - f0);
        end else begin
            checks++;
            if ({ev_inv[n0], ev_inv[n0+1], ev_inv[n0+2]} !== 3'b110) begin
                errors++;
                $display("FAIL b2b_inv: inv seq=%b%b%b, required 110", ev_inv[n0], ev_inv[n0+1], ev_inv[n0+2]);
            end
            checks++;
            if (ev_pulse[n0] !== 7'd0 || ev_pulse[n0+1] !== 7'b0010000 || ev_pulse[n0+2] !== 7'd0) begin
                errors++;
                $display("FAIL b2b_pulses: %b %b %b, required 0000000 0010000 0000000",
                         ev_pulse[n0], ev_pulse[n0+1], ev_pulse[n0+2]);
            end
        end
    endtask

    task automatic test_break();
        int n0 = ev_byte.size();
        int f0 = ferr_byte.size();
        send(8'h41, 1'b0, 1'b0);
        uRxI = 1'b0;
        repeat (20 * CLK_DIV) @(negedge clkI);
        checks++;
        if (rxByteO !== 8'h46) begin
            errors++;
            $display("FAIL break_hold: rxByteO=%h, required 46", rxByteO);
        end
        repeat (20 * CLK_DIV) @(negedge clkI);
        idle(2 * CLK_DIV);
        send("X", 1'b1, 1'b0);
        idle(2 * CLK_DIV);
        checks++;
        if (ferr_byte.size() - f0 != 1) begin
            errors++;
            $display("FAIL break_ferr_count: got %0d, required 1", ferr_byte.size() - f0);
        end else begin
            checks++;
            if (ferr_byte[f0] !== 8'h46) begin
                errors++;
                $display("FAIL break_ferr_byte: rxByteO=%h at error, required 46", ferr_byte[f0]);
            end
        end
        checks++;
        if (ev_byte.size() - n0 != 1) begin
            errors++;
            $display("FAIL break_valid_count: got %0d, required 1", ev_byte.size() - n0);
        end else begin
            checks++;
            if (ev_byte[n0] !== 8'h58 || ev_pulse[n0] !== 7'b0100000) begin
                errors++;
                $display("FAIL break_X: byte=%h pulses=%b, required 58/0100000", ev_byte[n0], ev_pulse[n0]);
            end
        end
    endtask

    task automatic test_glitch();
        int n0 = ev_byte.size();
        int f0 = ferr_byte.size();
        uRxI = 1'b0;
        repeat (5) @(negedge clkI);
        idle(12 * CLK_DIV);
        checks++;
        if (ev_byte.size() != n0 || ferr_byte.size() != f0) begin
            errors++;
            $display("FAIL glitch_quiet: valid=%0d ferr=%0d, required 0/0", ev_byte.size() - n0, ferr_byte.size() - f0);
        end
        send("D", 1'b1, 1'b0);
        idle(2 * CLK_DIV);
        checks++;
        if (ev_byte.size() - n0 != 1 || ev_pulse[ev_pulse.size()-1] !== 7'b0000010) begin
            errors++;
            $display("FAIL glitch_D: valid=%0d, last pulses=%b, required 1/0000010",
                     ev_byte.size() - n0, ev_pulse[ev_pulse.size()-1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        int f0;
        logic [7:0] b = "U";
        send("R", 1'b1, 1'b0);
        idle(2 * CLK_DIV);
        n0 = ev_byte.size();
        f0 = ferr_byte.size();
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(b[i]);
        uRxI = b[4];
        repeat (CLK_DIV / 2) @(negedge clkI);
        rstI = 1'b1;
        @(negedge clkI);
        rstI = 1'b0;
        uRxI = 1'b1;
        checks++;
        if (m3invRotateO !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_inv: m3invRotateO=%b, required 0", m3invRotateO);
        end
        idle(15 * CLK_DIV);
        checks++;
        if (ev_byte.size() != n0 || ferr_byte.size() != f0) begin
            errors++;
            $display("FAIL rstmid_quiet: valid=%0d ferr=%0d, required 0/0", ev_byte.size() - n0, ferr_byte.size() - f0);
        end
        send("U", 1'b1, 1'b0);
        idle(2 * CLK_DIV);
        checks++;
        if (ev_byte.size() - n0 != 1 || ev_pulse[ev_pulse.size()-1] !== 7'b0000100 || m3invRotateO !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_U: valid=%0d pulses=%b inv=%b, required 1/0000100/0",
                     ev_byte.size() - n0, ev_pulse[ev_pulse.size()-1], m3invRotateO);
        end
    endtask

    task automatic test_random();
        logic [7:0] sent[$];
        logic       inv_m = 1'b0;
        int n0 = ev_byte.size();
        int f0 = ferr_byte.size();
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i % 4 == 1) b = (($urandom & 1) != 0) ? 8'h52 : 8'h46;
            sent.push_back(b);
            send(b, 1'b1, 1'b0);
            idle($urandom_range(0, 20));
        end
        idle(2 * CLK_DIV);
        checks++;
        if (ev_byte.size() - n0 != sent.size() || ferr_byte.size() != f0) begin
            errors++;
            $display("FAIL rand_count: valid=%0d ferr=%0d, required %0d/0",
                     ev_byte.size() - n0, ferr_byte.size() - f0, sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                if (sent[i] == 8'h52) inv_m = 1'b1;
                if (sent[i] == 8'h46) inv_m = 1'b0;
                checks++;
                if (ev_byte[n0+i] !== sent[i] || ev_pulse[n0+i] !== model_pulses(sent[i]) || ev_inv[n0+i] !== inv_m) begin
                    errors++;
                    $display("FAIL rand_frame%0d: byte=%h pulses=%b inv=%b, required %h/%b/%b", i,
                             ev_byte[n0+i], ev_pulse[n0+i], ev_inv[n0+i], sent[i], model_pulses(sent[i]), inv_m);
                end
            end
        end
    endtask

`ifdef MOTOR602_RX_PARITY_EN
    task automatic test_parity();
        int n0 = ev_byte.size();
        int f0 = ferr_byte.size();
        send(8'h53, 1'b1, 1'b0);
        idle(2 * CLK_DIV);
        checks++;
        if (ev_byte.size() - n0 != 1 || ev_pulse[ev_pulse.size()-1] !== 7'b1000000) begin
            errors++;
            $display("FAIL parity_good: valid=%0d, required 1 with m3startO", ev_byte.size() - n0);
        end
        send(8'h53, 1'b1, 1'b1);
        idle(2 * CLK_DIV);
        checks++;
        if (ev_byte.size() - n0 != 1 || ferr_byte.size() - f0 != 1) begin
            errors++;
            $display("FAIL parity_bad: valid=%0d ferr=%0d, required 1/1", ev_byte.size() - n0, ferr_byte.size() - f0);
        end
    endtask
`endif

    initial begin
        @(negedge clkI);
        test_reset();
        test_single();
        test_back_to_back();
        test_break();
        test_glitch();
        test_reset_mid_frame();
        test_random();
`ifdef MOTOR602_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (stray_cnt != 0) begin
            errors++;
            $display("FAIL stray_pulses: %0d command pulses without rxValidO, required 0", stray_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
